// File: rtl/block_fade.sv
// Per-channel duty-cycle fade engine: register writes set per-channel targets and a
// global slew rate; live duty bytes ramp toward their targets once per prescaler tick.
module block_fade #(
    parameter int unsigned CHANNELS = 7,
    parameter int unsigned TICK_DIV = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            wr_data,
    input  logic [7:0]            wr_address,
    input  logic                  wr_valid,
    output logic [8*CHANNELS-1:0] duty_out,
    output logic                  busy
);

    localparam int unsigned CNT_W      = $clog2(TICK_DIV);
    localparam logic [7:0]  ADDR_RATE  = 8'h80;
    localparam logic [7:0]  ADDR_CLEAR = 8'hFF;

    logic [CNT_W-1:0] presc_cnt;
    logic             tick_c;
    logic [7:0]       rate;
    logic [7:0]       rate_nxt;
    logic [7:0]       target     [CHANNELS];
    logic [7:0]       duty       [CHANNELS];
    logic [7:0]       target_nxt [CHANNELS];
    logic [7:0]       duty_nxt   [CHANNELS];
    logic             clear_c;

    // One slew step toward tgt; 9-bit arithmetic so the result clamps instead of wrapping.
    function automatic logic [7:0] fade_step(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] stp);
        logic [8:0] up;
        logic [8:0] dn;
        up = {1'b0, cur} + {1'b0, stp};
        dn = {1'b0, cur} - {1'b0, stp};
        fade_step = cur;
        if (cur < tgt) begin
            fade_step = (up > {1'b0, tgt}) ? tgt : up[7:0];
        end else if (cur > tgt) begin
            fade_step = (dn[8] || (dn[7:0] < tgt)) ? tgt : dn[7:0];
        end
    endfunction

    assign tick_c  = (presc_cnt == CNT_W'(TICK_DIV - 1));
    assign clear_c = wr_valid && (wr_address == ADDR_CLEAR);

    // Free-running prescaler; writes never disturb its phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick_c) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + CNT_W'(1);
        end
    end

    // Next-state: slew (or snap in immediate mode), then register writes, then clear.
    always_comb begin
        rate_nxt = rate;
        if (wr_valid && (wr_address == ADDR_RATE)) begin
            rate_nxt = wr_data;
        end
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            target_nxt[k] = target[k];
            duty_nxt[k]   = duty[k];
            if (rate == 8'd0) begin
                duty_nxt[k] = target[k];
            end else if (tick_c) begin
                duty_nxt[k] = fade_step(duty[k], target[k], rate);
            end
            if (wr_valid && (wr_address == 8'(k + 1))) begin
                target_nxt[k] = wr_data;
                if (rate == 8'd0) begin
                    duty_nxt[k] = wr_data;
                end
            end
            if (clear_c) begin
                target_nxt[k] = 8'd0;
                duty_nxt[k]   = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate <= 8'd1;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                target[k] <= 8'd0;
                duty[k]   <= 8'd0;
            end
        end else begin
            rate <= rate_nxt;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                target[k] <= target_nxt[k];
                duty[k]   <= duty_nxt[k];
            end
        end
    end

    // Busy reflects the registers directly so it drops on the cycle a channel settles.
    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            busy = busy | (duty[k] != target[k]);
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_pack
        assign duty_out[8*g +: 8] = duty[g];
    end

endmodule

// File: tb/tb_block_fade.sv
// Bench for block_fade: directed fade scenarios plus random writes, all checked
// every cycle against an integer-arithmetic reference model.
module tb_block_fade;

    localparam int CH = 7;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      wr_data = 8'd0;
    logic [7:0]      wr_address = 8'd0;
    logic            wr_valid = 1'b0;
    logic [8*CH-1:0] duty_out;
    logic            busy;

    int checks = 0;
    int errors = 0;

    block_fade #(.CHANNELS(CH), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_address(wr_address),
        .wr_valid  (wr_valid),
        .duty_out  (duty_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel integers stepped by min/max once every TD cycles.
    int m_t [1:CH];
    int m_d [1:CH];
    int m_rate;
    int m_cnt;

    always @(posedge clk or negedge rst_n) begin : model
        bit tk;
        int r;
        int a;
        if (!rst_n) begin
            for (int c = 1; c <= CH; c++) begin
                m_t[c] = 0;
                m_d[c] = 0;
            end
            m_rate = 1;
            m_cnt  = 0;
        end else begin
            tk = ((m_cnt % TD) == TD - 1);
            m_cnt++;
            r = m_rate;
            for (int c = 1; c <= CH; c++) begin
                if (r == 0) m_d[c] = m_t[c];
                else if (tk) begin
                    if (m_d[c] < m_t[c])      m_d[c] = (m_d[c] + r > m_t[c]) ? m_t[c] : m_d[c] + r;
                    else if (m_d[c] > m_t[c]) m_d[c] = (m_d[c] - r < m_t[c]) ? m_t[c] : m_d[c] - r;
                end
            end
            if (wr_valid) begin
                a = int'(wr_address);
                if (a >= 1 && a <= CH) begin
                    m_t[a] = int'(wr_data);
                    if (r == 0) m_d[a] = int'(wr_data);
                end else if (a == 128) begin
                    m_rate = int'(wr_data);
                end else if (a == 255) begin
                    for (int c = 1; c <= CH; c++) begin
                        m_t[c] = 0;
                        m_d[c] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [8*CH-1:0] e;
        bit b;
        if (rst_n) begin
            b = 1'b0;
            for (int c = 1; c <= CH; c++) begin
                e[8*c-8 +: 8] = 8'(m_d[c]);
                b = b | (m_d[c] != m_t[c]);
            end
            check("model_duty_out", 64'(duty_out), 64'(e));
            check("model_busy", 64'(busy), 64'(b));
        end
    end

    task automatic put(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_address = a; wr_data = d;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        wr_valid = 1'b0; wr_address = 8'd0; wr_data = 8'd0;
    endtask

    logic [7:0] exp_seq [$];

    // Record each change of one channel's duty and compare it with exp_seq in order.
    task automatic watch(input int ch, input int budget, input string name);
        logic [7:0] last;
        logic [7:0] cur;
        int idx;
        int cyc;
        last = duty_out[8*ch-8 +: 8];
        idx = 0;
        cyc = 0;
        while (idx < exp_seq.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            cur = duty_out[8*ch-8 +: 8];
            if (cur != last) begin
                check(name, 64'(cur), 64'(exp_seq[idx]));
                idx++;
                last = cur;
            end
        end
        if (idx < exp_seq.size()) check({name, "_timeout_steps"}, 64'(idx), 64'(exp_seq.size()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stim
        int cyc;
        logic [7:0] a;
        logic [7:0] d;
        int r;

        repeat (3) @(negedge clk);
        check("reset_duty_out", 64'(duty_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Fade up at the reset rate of 1.
        put(8'd1, 8'h10);
        idle();
        exp_seq.delete();
        for (int v = 1; v <= 16; v++) exp_seq.push_back(8'(v));
        watch(1, 200, "fadeup_duty1");
        check("fadeup_busy_low_at_end", 64'(busy), 64'd0);
        check("fadeup_others_zero", 64'(duty_out[8*CH-1:8]), 64'd0);

        // Clamped steps up and down at rate 0x30.
        put(8'h80, 8'h30);
        put(8'd3, 8'hFA);
        idle();
        exp_seq = '{8'h30, 8'h60, 8'h90, 8'hC0, 8'hF0, 8'hFA};
        watch(3, 100, "clamp_up_duty3");
        put(8'd3, 8'h05);
        idle();
        exp_seq = '{8'hCA, 8'h9A, 8'h6A, 8'h3A, 8'h0A, 8'h05};
        watch(3, 100, "clamp_dn_duty3");

        // Immediate mode.
        put(8'h80, 8'h00);
        put(8'd7, 8'hA5);
        idle();
        check("immediate_duty7", 64'(duty_out[55:48]), 64'hA5);
        check("immediate_busy", 64'(busy), 64'd0);

        // Clear coincident with a tick while ch2 fades up.
        put(8'h80, 8'h01);
        put(8'd2, 8'hFF);
        idle();
        cyc = 0;
        while (duty_out[15:8] != 8'h40 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("clear_reach_40", 64'(duty_out[15:8]), 64'h40);
        repeat (2) @(posedge clk);
        put(8'hFF, 8'h00);
        idle();
        @(negedge clk);
        check("clear_duty_out", 64'(duty_out), 64'd0);
        check("clear_busy", 64'(busy), 64'd0);

        // Back-to-back writes, retarget, and ignored addresses.
        put(8'd1, 8'h80);
        put(8'd2, 8'h80);
        put(8'd1, 8'h20);
        put(8'h00, 8'h77);
        put(8'h55, 8'h99);
        put(8'h08, 8'h44);
        idle();
        cyc = 0;
        while (busy && cyc < 800) begin
            @(negedge clk);
            cyc++;
        end
        check("retarget_settled_busy", 64'(busy), 64'd0);
        check("retarget_duty1", 64'(duty_out[7:0]), 64'h20);
        check("retarget_duty2", 64'(duty_out[15:8]), 64'h80);
        check("retarget_others", 64'(duty_out[8*CH-1:16]), 64'd0);

        // Random writes against the model.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            wr_valid = ($urandom % 3) == 0;
            r = int'($urandom % 16);
            d = 8'($urandom);
            if (r < 7)       a = 8'(r + 1);
            else if (r < 9) begin
                a = 8'h80;
                case ($urandom % 4)
                    0: d = 8'd0;
                    1: d = 8'd1;
                    2: d = 8'($urandom_range(2, 16));
                    default: d = 8'($urandom);
                endcase
            end
            else if (r == 9)  a = (($urandom % 8) == 0) ? 8'hFF : 8'd1;
            else if (r == 10) a = 8'h00;
            else if (r == 11) a = 8'h55;
            else if (r == 12) a = 8'h08;
            else              a = 8'($urandom_range(1, CH));
            wr_address = a;
            wr_data = d;
        end
        idle();

        // Reset mid-fade, then the first tick lands TD cycles after release.
        put(8'h80, 8'h01);
        put(8'd4, 8'hFF);
        idle();
        repeat (40) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_duty_out", 64'(duty_out), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        put(8'd1, 8'h01);
        idle();
        @(negedge clk);
        check("postreset_edge2_duty1", 64'(duty_out[7:0]), 64'd0);
        @(negedge clk);
        check("postreset_edge3_duty1", 64'(duty_out[7:0]), 64'd0);
        @(negedge clk);
        check("postreset_first_tick_duty1", 64'(duty_out[7:0]), 64'd1);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
